scan_mux: RTL and testbench
===========================

# scan_mux

Parametrised, time-multiplexed digit scanner for the 7-segment display path. It selects one of `CHANNELS` segment words, presents it on a registered output, and drives a matching one-hot digit-enable. In auto mode it advances through the channels on an internal prescaler; in manual mode it tracks an external select. It sits between the per-digit segment encoders and the display pins, and replaces the fixed 4-channel registered selector.

## Interface
- `WIDTH`, default 8: segment word width (7 segments plus decimal point).
- `CHANNELS`, default 4: number of digits; legal range 2..16.
- `DIV`, default 1000: clock cycles per digit in auto mode; must be ≥ 2.
- `BLANK_CYC`, default 2: blanking cycles at the start of each digit period; must be < `DIV`. Used only with `SCAN_MUX_BLANK_EN`.
- `SW` (localparam) = `$clog2(CHANNELS)`.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_en` in 1: scan enable; when low, outputs are dark and counters hold.
- `i_mode` in 1: 0 = auto scan, 1 = manual select.
- `i_sel` in SW: manual channel index.
- `i_data` in CHANNELS*WIDTH: flattened words; channel k occupies `[k*WIDTH +: WIDTH]`.
- `o_data` out WIDTH: registered segment word.
- `o_sel` out CHANNELS: registered one-hot digit enable.
- `o_idx` out SW: registered index of the displayed channel.
- `o_tick` out 1: one-cycle pulse in the cycle `o_idx` takes a new auto-scan value.

## Operation
- Internal state:
  - `cnt`: width `$clog2(DIV)`, range 0..DIV-1.
  - `idx`: width SW.
  - `oor`: out-of-range flag.
  - `tick_q`.
- Auto mode (`i_en`=1, `i_mode`=0):
  - `cnt` increments each cycle.
  - At `cnt`==DIV-1: `cnt` goes to 0, `idx` goes to `idx`+1, wrapping from CHANNELS-1 to 0 (correct for non-power-of-2 CHANNELS), and `tick_q` goes to 1. Otherwise `tick_q` is 0.
- Manual mode (`i_en`=1, `i_mode`=1):
  - `cnt` goes to 0 and `tick_q` to 0.
  - If `i_sel` < CHANNELS: `idx` goes to `i_sel` and `oor` to 0.
  - Otherwise `idx` holds and `oor` goes to 1.
- Switching manual to auto: scan resumes from the current `idx` with `cnt`=0. `oor` clears on the first auto cycle.
- Disabled (`i_en`=0):
  - `cnt` and `idx` hold; `tick_q` goes to 0.
  - Outputs are registered to `o_data`=0 and `o_sel`=0; `o_idx` holds.
- Output register, each enabled cycle, from pre-edge state:
  - `o_data` gets the slice of `idx`, `o_sel` gets `1<<idx`, `o_idx` gets `idx`, `o_tick` gets `tick_q`.
  - If `oor`=1: `o_data`=0 and `o_sel`=0.
- `o_sel` is always one-hot or all-zero. It is never multi-hot.

## Timing
- Reset values: `cnt`=0, `idx`=0, `oor`=0, `tick_q`=0, `o_data`=0, `o_sel`=0, `o_idx`=0, `o_tick`=0. Reset overrides `i_en` and `i_mode`.
- Reset mid-scan returns to channel 0 with a full DIV period.
- Latency:
  - `i_data` to `o_data`: 1 cycle.
  - `idx` to `o_*`: 1 cycle.
  - `i_sel` to `o_*`: 2 cycles.
  - `i_en` fall to dark outputs: 1 cycle.
- Auto dwell: each channel shows for exactly DIV cycles. The full frame is CHANNELS*DIV cycles. `o_tick` is high exactly in the first cycle of each new `o_idx`.
- After reset release with `i_en`=1, `o_sel`=one-hot(0) from the first edge. Channel 0's first dwell is DIV cycles counted from that edge.
- `i_data` may change at any time. The new value appears on the next edge and does not disturb the scan.

## Configuration
- `SCAN_MUX_BLANK_EN` defined: in auto mode, whenever pre-edge `cnt` < BLANK_CYC, the output register loads `o_data`=0 and `o_sel`=0. `o_idx` and `o_tick` still update. This gives anti-ghosting dead time at each digit change. Manual mode is never blanked.
- Undefined: no blanking logic is built, `BLANK_CYC` is ignored, and the digit drives for all DIV cycles.

## Test plan
- Reset: run auto scan, assert `i_rst` for 2 cycles mid-period → all outputs 0 during reset. After release, `o_sel`=4'b0001 and `o_data`=ch0 for DIV cycles.
- Auto scan with WIDTH=8, CHANNELS=4, DIV=4, data ch0..3 = 8'h11/22/33/44 → `o_sel` steps 0001, 0010, 0100, 1000, 0001 every 4 cycles. `o_data` follows 11, 22, 33, 44, 11. `o_tick` pulses at each step only.
- Manual select: `i_mode`=1, `i_sel`=2 → two cycles later `o_data`=8'h33, `o_sel`=0100, `o_tick`=0 throughout. Return to auto → 0100 held for 4 cycles, then 1000.
- Out of range with CHANNELS=3: manual `i_sel`=3 → `o_data`=0, `o_sel`=000, `o_idx` unchanged. Then `i_sel`=1 → `o_sel`=010. Also check auto wrap 2 to 0.
- Enable gap: drop `i_en` for 3 cycles after 2 cycles of ch1 → outputs 0 one cycle later. On re-enable, ch1 shows for the remaining 2 cycles, then ch2.
- With `SCAN_MUX_BLANK_EN`, DIV=4, BLANK_CYC=1: each 4-cycle digit period shows `o_sel`=0000 for its first cycle, then one-hot for 3 cycles. `o_tick` still lands on the first cycle of each period.

Source files
------------

// File: rtl/scan_mux.sv
// Time-multiplexed 7-segment digit scanner: auto scan on a prescaler or manual select.
// Define SCAN_MUX_BLANK_EN to build the auto-mode anti-ghosting blanking window.
module scan_mux #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2,
    localparam int SW       = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic [SW-1:0]             i_sel,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]          o_data,
    output logic [CHANNELS-1:0]       o_sel,
    output logic [SW-1:0]             o_idx,
    output logic                      o_tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0]       cnt;
    logic [SW-1:0]       idx;
    logic                oor;
    logic                tick_q;
    logic [WIDTH-1:0]    word;
    logic [CHANNELS-1:0] onehot;
    logic                sel_ok;
    logic                wrap;
    logic                dark;

    always_comb begin
        word   = '0;
        onehot = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (idx == SW'(k)) begin
                word      = i_data[k*WIDTH +: WIDTH];
                onehot[k] = 1'b1;
            end
        end
        sel_ok = ({1'b0, i_sel} < (SW+1)'(CHANNELS));
        wrap   = (cnt == CW'(DIV - 1));
        dark   = oor;
`ifdef SCAN_MUX_BLANK_EN
        // Dead time at the start of every auto digit period; manual mode is never blanked.
        if (!i_mode && (cnt < CW'(BLANK_CYC)))
            dark = 1'b1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            idx    <= '0;
            oor    <= 1'b0;
            tick_q <= 1'b0;
            o_data <= '0;
            o_sel  <= '0;
            o_idx  <= '0;
            o_tick <= 1'b0;
        end else if (!i_en) begin
            tick_q <= 1'b0;
            o_data <= '0;
            o_sel  <= '0;
            o_tick <= 1'b0;
        end else begin
            o_idx  <= idx;
            o_tick <= tick_q;
            o_data <= dark ? '0 : word;
            o_sel  <= dark ? '0 : onehot;
            if (i_mode) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                if (sel_ok) begin
                    idx <= i_sel;
                    oor <= 1'b0;
                end else begin
                    oor <= 1'b1;
                end
            end else begin
                oor <= 1'b0;
                if (wrap) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    idx    <= (idx == SW'(CHANNELS - 1)) ? '0 : idx + SW'(1);
                end else begin
                    cnt    <= cnt + CW'(1);
                    tick_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: a 4-channel and a 3-channel instance (DIV=4) checked every cycle
// against an elapsed-time model of the scan (channel = base + elapsed/DIV mod CHANNELS).
module tb_scan_mux;

    localparam int DIVP = 4;
    localparam int BLK  = 1;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [1:0]  sel;
    logic [31:0] data_a;
    logic [23:0] data_b;
    logic [7:0]  a_data, b_data;
    logic [3:0]  a_sel;
    logic [2:0]  b_sel;
    logic [1:0]  a_idx, b_idx;
    logic        a_tick, b_tick;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] words [2][4];
    int         m_base [2];
    int         m_el   [2];
    bit         m_oor  [2];
    bit         m_last [2];
    logic [7:0] e_data [2];
    logic [3:0] e_sel  [2];
    logic [1:0] e_idx  [2];
    logic       e_tick [2];

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(8), .CHANNELS(4), .DIV(DIVP), .BLANK_CYC(BLK)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel),
        .i_data(data_a), .o_data(a_data), .o_sel(a_sel), .o_idx(a_idx), .o_tick(a_tick)
    );

    scan_mux #(.WIDTH(8), .CHANNELS(3), .DIV(DIVP), .BLANK_CYC(BLK)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel),
        .i_data(data_b), .o_data(b_data), .o_sel(b_sel), .o_idx(b_idx), .o_tick(b_tick)
    );

    function automatic int nch(int u);
        return (u == 0) ? 4 : 3;
    endfunction

    task automatic set_data();
        data_a = {words[0][3], words[0][2], words[0][1], words[0][0]};
        data_b = {words[1][2], words[1][1], words[1][0]};
    endtask

    // Predict the outputs of the coming edge from the inputs presented before it.
    task automatic model(int u);
        int ch, phase;
        bit dark;
        if (rst) begin
            m_base[u] = 0; m_el[u] = 0; m_oor[u] = 0; m_last[u] = 0;
            e_data[u] = '0; e_sel[u] = '0; e_idx[u] = '0; e_tick[u] = 1'b0;
        end else if (!en) begin
            e_data[u] = '0; e_sel[u] = '0; e_tick[u] = 1'b0;
            m_last[u] = 0;
        end else begin
            ch    = (m_base[u] + m_el[u] / DIVP) % nch(u);
            phase = m_el[u] % DIVP;
            dark  = m_oor[u];
`ifdef SCAN_MUX_BLANK_EN
            if (!mode && phase < BLK) dark = 1;
`endif
            e_idx[u]  = 2'(ch);
            e_tick[u] = m_last[u] && (phase == 0);
            e_data[u] = dark ? 8'h00 : words[u][ch];
            e_sel[u]  = dark ? 4'h0 : 4'(1 << ch);
            if (mode) begin
                if (int'(sel) < nch(u)) begin
                    m_base[u] = int'(sel);
                    m_oor[u]  = 0;
                end else begin
                    m_base[u] = ch;
                    m_oor[u]  = 1;
                end
                m_el[u]   = 0;
                m_last[u] = 0;
            end else begin
                m_el[u]   = m_el[u] + 1;
                m_oor[u]  = 0;
                m_last[u] = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] od, logic [3:0] os, logic [1:0] oi, logic ot, int u);
        vectors++;
        assert (od === e_data[u]) else begin
            miscompares++;
            $error("FAIL %s data observed %h expected %h", tag, od, e_data[u]);
        end
        vectors++;
        assert (os === e_sel[u]) else begin
            miscompares++;
            $error("FAIL %s sel observed %b expected %b", tag, os, e_sel[u]);
        end
        vectors++;
        assert (oi === e_idx[u]) else begin
            miscompares++;
            $error("FAIL %s idx observed %0d expected %0d", tag, oi, e_idx[u]);
        end
        vectors++;
        assert (ot === e_tick[u]) else begin
            miscompares++;
            $error("FAIL %s tick observed %b expected %b", tag, ot, e_tick[u]);
        end
    endtask

    task automatic cycle(string tag, int n);
        for (int i = 0; i < n; i++) begin
            model(0);
            model(1);
            @(posedge clk);
            #1;
            chk({tag, "/c4"}, a_data, a_sel, a_idx, a_tick, 0);
            chk({tag, "/c3"}, b_data, {1'b0, b_sel}, b_idx, b_tick, 1);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0;
        words[0][0] = 8'h11; words[0][1] = 8'h22; words[0][2] = 8'h33; words[0][3] = 8'h44;
        words[1][0] = 8'h11; words[1][1] = 8'h22; words[1][2] = 8'h33; words[1][3] = 8'h00;
        set_data();
        cycle("reset", 2);

        rst = 1'b0;
        cycle("auto", 18);

        rst = 1'b1;
        cycle("midrst", 2);
        rst = 1'b0;
        cycle("post_rst", 14);

        mode = 1'b1; sel = 2'd2;
        cycle("manual", 4);
        mode = 1'b0;
        cycle("resume", 8);

        mode = 1'b1; sel = 2'd3;
        cycle("oor", 3);
        sel = 2'd1;
        cycle("oor_clear", 3);
        mode = 1'b0;
        cycle("wrap", 14);

        rst = 1'b1;
        cycle("gap_rst", 1);
        rst = 1'b0;
        cycle("gap_pre", DIVP + 2);
        en = 1'b0;
        cycle("gap_off", 3);
        en = 1'b1;
        cycle("gap_on", 8);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 10) begin
                words[$urandom_range(1)][$urandom_range(3)] = 8'($urandom);
                set_data();
            end
            en  = ($urandom_range(9) != 0);
            if ($urandom_range(24) == 0) mode = ~mode;
            sel = 2'($urandom_range(3));
            rst = ($urandom_range(149) == 0);
            cycle("rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
